// File: rtl/tranca_ctrl_pkg.sv
// Shared lock types: password/setup records, controller state encoding and password helpers.
package tranca_ctrl_pkg;

    typedef logic [79:0] senhaPac_t;

    typedef struct packed {
        logic       bip_status;
        logic [7:0] bip_time;
        logic [7:0] tranca_aut_time;
        senhaPac_t  senha_master;
        senhaPac_t  senha_1;
        senhaPac_t  senha_2;
        senhaPac_t  senha_3;
        senhaPac_t  senha_4;
    } setupPac_t;

    typedef enum logic [2:0] {
        TRAVADO      = 3'd0,
        DESTRAVADO   = 3'd1,
        PORTA_ABERTA = 3'd2,
        BLOQUEADO    = 3'd3,
        SETUP        = 3'd4
    } estado_tranca_t;

    localparam senhaPac_t SENHA_VAZIA = {20{4'hF}};

    // An all-F slot is an empty record and must never open the lock.
    function automatic logic senha_ok(senhaPac_t digitos, senhaPac_t slot);
        return (slot != SENHA_VAZIA) && (digitos == slot);
    endfunction

    // True on the tick that brings the second counter up to lim (lim=0 fires on the first tick).
    function automatic logic seg_fim(logic tick, logic [7:0] cnt, logic [7:0] lim);
        return tick && (({1'b0, cnt} + 9'd1) >= {1'b0, lim});
    endfunction

endpackage

// File: rtl/tranca_ctrl_if.sv
// Keypad, sensor, setup and actuator signals shared between the lock controller and its environment.
interface tranca_ctrl_if;
    import tranca_ctrl_pkg::*;

    setupPac_t  setup_pac;
    senhaPac_t  digitos_value;
    logic       digitos_valid;
    logic       setup_req;
    logic       setup_done;
    logic       botao_interno;
    logic       porta_fechada;
    logic       tranca;
    logic       bip;
    logic       setup_on;
    logic [2:0] estado_o;
    logic [3:0] falhas_o;

    modport master (
        output setup_pac, digitos_value, digitos_valid, setup_req, setup_done,
               botao_interno, porta_fechada,
        input  tranca, bip, setup_on, estado_o, falhas_o
    );

    modport slave (
        input  setup_pac, digitos_value, digitos_valid, setup_req, setup_done,
               botao_interno, porta_fechada,
        output tranca, bip, setup_on, estado_o, falhas_o
    );
endinterface

// File: rtl/tranca_ctrl_tick_seg.sv
// One-second prescaler: seg_tick pulses for one cycle every TICKS_POR_SEG cycles; clr restarts the period.
module tick_seg #(
    parameter int TICKS_POR_SEG = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic seg_tick
);
    localparam int W = (TICKS_POR_SEG > 1) ? $clog2(TICKS_POR_SEG) : 1;
    localparam logic [W-1:0] ULTIMO = W'(TICKS_POR_SEG - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || seg_tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign seg_tick = (cnt == ULTIMO);
endmodule

// File: rtl/tranca_ctrl.sv
// Electronic lock operational controller: bolt, buzzer, auto-relock, setup handoff.
// Optional LOCKOUT_EN adds wrong-password counting and the BLOQUEADO lockout state.
module tranca_ctrl
    import tranca_ctrl_pkg::*;
#(
    parameter int TICKS_POR_SEG = 1000,
    parameter int MAX_FALHAS    = 5,
    parameter int BLOQ_SEG      = 30
) (
    input logic          clk,
    input logic          rst,
    tranca_ctrl_if.slave bus
);
    estado_tranca_t state, state_d;
    logic [7:0]     seg_cnt;
    logic [3:0]     falhas, falhas_d;
    logic           bip, bip_d;
    logic           seg_tick;
    logic           restart, restart_btn;
    logic           match, master_ok;

`ifdef LOCKOUT_EN
    localparam logic [3:0] MAX_F  = 4'(MAX_FALHAS);
    localparam logic [7:0] BLOQ_S = 8'(BLOQ_SEG);
    logic [3:0] falhas_inc;
    assign falhas_inc = falhas + 4'd1;
`else
    logic unused_cfg;
    assign unused_cfg = ^{8'(MAX_FALHAS), 8'(BLOQ_SEG)};
`endif

    tick_seg #(.TICKS_POR_SEG(TICKS_POR_SEG)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (restart),
        .seg_tick (seg_tick)
    );

    assign master_ok = senha_ok(bus.digitos_value, bus.setup_pac.senha_master);
    assign match     = master_ok
                     | senha_ok(bus.digitos_value, bus.setup_pac.senha_1)
                     | senha_ok(bus.digitos_value, bus.setup_pac.senha_2)
                     | senha_ok(bus.digitos_value, bus.setup_pac.senha_3)
                     | senha_ok(bus.digitos_value, bus.setup_pac.senha_4);

    always_comb begin
        state_d     = state;
        falhas_d    = falhas;
        bip_d       = 1'b0;
        restart_btn = 1'b0;
        case (state)
            TRAVADO: begin
                if (bus.botao_interno) begin
                    state_d = DESTRAVADO;
                end else if (bus.digitos_valid) begin
                    if (match) begin
                        state_d  = DESTRAVADO;
                        falhas_d = 4'd0;
                    end
`ifdef LOCKOUT_EN
                    else begin
                        falhas_d = (falhas >= MAX_F) ? MAX_F : falhas_inc;
                        if (falhas_inc >= MAX_F)
                            state_d = BLOQUEADO;
                    end
`endif
                end
                // Forced door: alarm follows the sensor while the bolt stays thrown.
                if (state_d == TRAVADO)
                    bip_d = bus.setup_pac.bip_status & ~bus.porta_fechada;
            end
            DESTRAVADO: begin
                if (!bus.porta_fechada)
                    state_d = PORTA_ABERTA;
                else if (bus.digitos_valid && bus.setup_req && master_ok)
                    state_d = SETUP;
                else if (bus.botao_interno)
                    restart_btn = 1'b1;
                else if (seg_fim(seg_tick, seg_cnt, bus.setup_pac.tranca_aut_time))
                    state_d = TRAVADO;
            end
            PORTA_ABERTA: begin
                if (bus.porta_fechada)
                    state_d = DESTRAVADO;
                else
                    bip_d = bip | (bus.setup_pac.bip_status
                                   & (seg_cnt >= bus.setup_pac.bip_time));
            end
`ifdef LOCKOUT_EN
            BLOQUEADO: begin
                if (bus.botao_interno) begin
                    state_d  = DESTRAVADO;
                    falhas_d = 4'd0;
                end else if (seg_fim(seg_tick, seg_cnt, BLOQ_S)) begin
                    state_d  = TRAVADO;
                    falhas_d = 4'd0;
                end
            end
`endif
            SETUP: begin
                if (bus.setup_done)
                    state_d = DESTRAVADO;
            end
            default: state_d = TRAVADO;
        endcase
    end

    // Every state entry (and the inside button while unlocked) restarts the time base.
    assign restart = (state_d != state) | restart_btn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TRAVADO;
            falhas  <= 4'd0;
            bip     <= 1'b0;
            seg_cnt <= 8'd0;
        end else begin
            state  <= state_d;
            falhas <= falhas_d;
            bip    <= bip_d;
            if (restart)
                seg_cnt <= 8'd0;
            else if (seg_tick && seg_cnt != 8'hFF)
                seg_cnt <= seg_cnt + 8'd1;
        end
    end

    assign bus.tranca   = (state == TRAVADO) || (state == BLOQUEADO);
    assign bus.bip      = bip;
    assign bus.setup_on = (state == SETUP);
    assign bus.estado_o = state;
    assign bus.falhas_o = falhas;
endmodule

// File: tb/tb_tranca_ctrl.sv
// Bench for tranca_ctrl: directed scenarios plus random traffic against a cycle-counting behavioural model.
module tb_tranca_ctrl;
    import tranca_ctrl_pkg::*;

    localparam int T    = 4;
    localparam int MAXF = 5;
    localparam int BLQ  = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    // model state: plain ints, time kept as cycles elapsed since entering the state
    int m_state, m_ciclos, m_falhas;
    bit m_bip;

    tranca_ctrl_if bus ();

    tranca_ctrl #(.TICKS_POR_SEG(T), .MAX_FALHAS(MAXF), .BLOQ_SEG(BLQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic senhaPac_t pin(input int unsigned n, input int len);
        senhaPac_t s;
        s = '1;
        for (int i = 0; i < len; i++) begin
            s[i*4 +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return s;
    endfunction

    function automatic bit model_match(input senhaPac_t v, input setupPac_t p, input bit only_master);
        senhaPac_t slots [5];
        slots = '{p.senha_master, p.senha_1, p.senha_2, p.senha_3, p.senha_4};
        for (int i = 0; i < (only_master ? 1 : 5); i++)
            if (slots[i] != {20{4'hF}} && v == slots[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ciclos = 0; m_falhas = 0; m_bip = 0;
    endtask

    task automatic model_step();
        int nx, sec_now, sec_new;
        bit tick, restart, nbip;
        setupPac_t p;
        p       = bus.setup_pac;
        sec_now = (m_ciclos / T > 255) ? 255 : m_ciclos / T;
        sec_new = ((m_ciclos + 1) / T > 255) ? 255 : (m_ciclos + 1) / T;
        tick    = ((m_ciclos + 1) % T) == 0;
        nx = m_state; restart = 0; nbip = 0;
        case (m_state)
            0: begin
                if (bus.botao_interno) nx = 1;
                else if (bus.digitos_valid) begin
                    if (model_match(bus.digitos_value, p, 0)) begin
                        nx = 1; m_falhas = 0;
                    end
`ifdef LOCKOUT_EN
                    else begin
                        m_falhas = (m_falhas + 1 > MAXF) ? MAXF : m_falhas + 1;
                        if (m_falhas >= MAXF) nx = 3;
                    end
`endif
                end
                if (nx == 0) nbip = p.bip_status && !bus.porta_fechada;
            end
            1: begin
                if (!bus.porta_fechada) nx = 2;
                else if (bus.digitos_valid && bus.setup_req &&
                         model_match(bus.digitos_value, p, 1)) nx = 4;
                else if (bus.botao_interno) restart = 1;
                else if (tick && sec_new >= int'(p.tranca_aut_time)) nx = 0;
            end
            2: begin
                if (bus.porta_fechada) nx = 1;
                else nbip = m_bip || (p.bip_status && sec_now >= int'(p.bip_time));
            end
            3: begin
                if (bus.botao_interno) begin nx = 1; m_falhas = 0; end
                else if (tick && sec_new >= BLQ) begin nx = 0; m_falhas = 0; end
            end
            default: if (bus.setup_done) nx = 1;
        endcase
        if (nx != m_state || restart) m_ciclos = 0;
        else if (m_ciclos < 1000000) m_ciclos++;
        m_state = nx;
        m_bip   = nbip;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_pw(input senhaPac_t v);
        bus.digitos_value = v;
        bus.digitos_valid = 1'b1;
        @(negedge clk);
        bus.digitos_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.digitos_valid = 1'b0;
        bus.digitos_value = '1;
        bus.setup_req     = 1'b0;
        bus.setup_done    = 1'b0;
        bus.botao_interno = 1'b0;
        bus.porta_fechada = 1'b1;
    endtask

    task automatic base_pac();
        bus.setup_pac.bip_status      = 1'b1;
        bus.setup_pac.bip_time        = 8'd3;
        bus.setup_pac.tranca_aut_time = 8'd5;
        bus.setup_pac.senha_master    = pin(5678, 4);
        bus.setup_pac.senha_1         = pin(1234, 4);
        bus.setup_pac.senha_2         = '1;
        bus.setup_pac.senha_3         = '1;
        bus.setup_pac.senha_4         = '1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        wait_neg(2);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic drive_random(input int c);
        int sel;
        if (c % 250 == 0) begin
            bus.setup_pac.bip_status      = 1'($urandom_range(0, 1));
            bus.setup_pac.bip_time        = 8'($urandom_range(0, 4));
            bus.setup_pac.tranca_aut_time = 8'($urandom_range(0, 6));
            bus.setup_pac.senha_master    = ($urandom_range(0, 4) == 0) ? '1 : pin($urandom_range(0, 9999), 4);
            bus.setup_pac.senha_1         = pin($urandom_range(0, 9999), 4);
            bus.setup_pac.senha_2         = ($urandom_range(0, 1) == 0) ? '1 : pin($urandom_range(0, 999), 3);
        end
        sel = $urandom_range(0, 4);
        case (sel)
            0:       bus.digitos_value = bus.setup_pac.senha_master;
            1:       bus.digitos_value = bus.setup_pac.senha_1;
            2:       bus.digitos_value = '1;
            default: bus.digitos_value = pin($urandom_range(0, 9999), 4);
        endcase
        bus.digitos_valid = ($urandom_range(0, 5) == 0);
        bus.setup_req     = 1'($urandom_range(0, 1));
        bus.botao_interno = ($urandom_range(0, 49) == 0);
        bus.setup_done    = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 29) == 0) bus.porta_fechada = ~bus.porta_fechada;
    endtask

    initial begin
        idle_inputs();
        base_pac();
        model_reset();
        wait_neg(2);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_tranca", 32'(bus.tranca), 32'd1);
        chk("rst_bip", 32'(bus.bip), 32'd0);
        chk("rst_setup_on", 32'(bus.setup_on), 32'd0);
        chk("rst_falhas", 32'(bus.falhas_o), 32'd0);
        chk("rst_estado", 32'(bus.estado_o), 32'd0);

        // unlock and auto-relock after 5 s
        pulse_pw(pin(1234, 4));
        chk("unlock_tranca", 32'(bus.tranca), 32'd0);
        wait_neg(19);
        chk("relock_before", 32'(bus.tranca), 32'd0);
        wait_neg(1);
        chk("relock_after", 32'(bus.tranca), 32'd1);
        chk("relock_estado", 32'(bus.estado_o), 32'd0);

        // door-open buzzer after bip_time seconds
        do_reset();
        pulse_pw(pin(1234, 4));
        bus.porta_fechada = 1'b0;
        wait_neg(13);
        chk("door_estado", 32'(bus.estado_o), 32'd2);
        chk("door_bip_early", 32'(bus.bip), 32'd0);
        wait_neg(1);
        chk("door_bip_on", 32'(bus.bip), 32'd1);
        bus.porta_fechada = 1'b1;
        wait_neg(1);
        chk("door_close_bip", 32'(bus.bip), 32'd0);
        chk("door_close_estado", 32'(bus.estado_o), 32'd1);

        // empty slot never matches; button beats a same-cycle strobe
        do_reset();
        pulse_pw('1);
        chk("empty_estado", 32'(bus.estado_o), 32'd0);
`ifdef LOCKOUT_EN
        chk("empty_falhas", 32'(bus.falhas_o), 32'd1);
`else
        chk("empty_falhas", 32'(bus.falhas_o), 32'd0);
`endif
        bus.botao_interno = 1'b1;
        pulse_pw(pin(9999, 4));
        bus.botao_interno = 1'b0;
        chk("btn_prio_estado", 32'(bus.estado_o), 32'd1);
`ifdef LOCKOUT_EN
        chk("btn_prio_falhas", 32'(bus.falhas_o), 32'd1);
`else
        chk("btn_prio_falhas", 32'(bus.falhas_o), 32'd0);
`endif

        // lockout
        do_reset();
        for (int i = 0; i < MAXF; i++) begin
            wait_neg(1);
            pulse_pw(pin(9999, 4));
        end
`ifdef LOCKOUT_EN
        chk("lock_estado", 32'(bus.estado_o), 32'd3);
        chk("lock_falhas", 32'(bus.falhas_o), 32'(MAXF));
        pulse_pw(pin(1234, 4));
        chk("lock_ignore_pw", 32'(bus.tranca), 32'd1);
        wait_neg(118);
        chk("lock_still", 32'(bus.estado_o), 32'd3);
        wait_neg(1);
        chk("lock_end_estado", 32'(bus.estado_o), 32'd0);
        chk("lock_end_falhas", 32'(bus.falhas_o), 32'd0);
        for (int i = 0; i < MAXF; i++) begin
            wait_neg(1);
            pulse_pw(pin(9999, 4));
        end
        bus.botao_interno = 1'b1;
        wait_neg(1);
        bus.botao_interno = 1'b0;
        chk("lock_btn_tranca", 32'(bus.tranca), 32'd0);
        chk("lock_btn_falhas", 32'(bus.falhas_o), 32'd0);
`else
        chk("nolock_estado", 32'(bus.estado_o), 32'd0);
        chk("nolock_falhas", 32'(bus.falhas_o), 32'd0);
        pulse_pw(pin(1234, 4));
        chk("nolock_unlock", 32'(bus.tranca), 32'd0);
`endif

        // setup handoff
        do_reset();
        pulse_pw(pin(1234, 4));
        bus.setup_req = 1'b1;
        pulse_pw(pin(5678, 4));
        chk("setup_on", 32'(bus.setup_on), 32'd1);
        chk("setup_estado", 32'(bus.estado_o), 32'd4);
        bus.botao_interno = 1'b1;
        pulse_pw(pin(1234, 4));
        bus.botao_interno = 1'b0;
        chk("setup_ignore", 32'(bus.estado_o), 32'd4);
        bus.setup_done = 1'b1;
        wait_neg(1);
        bus.setup_done = 1'b0;
        bus.setup_req  = 1'b0;
        chk("setup_exit_on", 32'(bus.setup_on), 32'd0);
        chk("setup_exit_estado", 32'(bus.estado_o), 32'd1);

        // asynchronous reset while the buzzer sounds
        do_reset();
        bus.setup_pac.bip_time = 8'd0;
        pulse_pw(pin(1234, 4));
        bus.porta_fechada = 1'b0;
        wait_neg(3);
        chk("arst_pre_bip", 32'(bus.bip), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tranca", 32'(bus.tranca), 32'd1);
        chk("arst_bip", 32'(bus.bip), 32'd0);
        chk("arst_estado", 32'(bus.estado_o), 32'd0);
        @(negedge clk);
        base_pac();
        do_reset();

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            drive_random(c);
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("rnd_estado", 32'(bus.estado_o), 32'(m_state));
            chk("rnd_tranca", 32'(bus.tranca), 32'((m_state == 0) || (m_state == 3)));
            chk("rnd_bip", 32'(bus.bip), 32'(m_bip));
            chk("rnd_setup_on", 32'(bus.setup_on), 32'(m_state == 4));
            chk("rnd_falhas", 32'(bus.falhas_o), 32'(m_falhas));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
